mac_rx_arbiter: RTL and testbench
=================================

Name: mac_rx_arbiter

Overview:
- Frame-granular round-robin scheduler that drains the receive FIFO pairs of NPORTS mac_r_* receive MACs into one byte stream for the switch core.
- Each MAC exposes a pointer FIFO (one 16-bit descriptor per frame) and a data FIFO (frame bytes).
- The arbiter pops one descriptor, reads exactly that many bytes from the same port's data FIFO, and forwards them with sof/eof/port tags under ready/valid backpressure.
- Sits between the per-port MAC receive blocks and the switch ingress, all in the clk_sys domain.

Parameters:
- NPORTS, 4, number of MAC receive ports; 2..8.
- PW, 2, width of port index; must satisfy 2**PW >= NPORTS.

Ports:
- clk_sys  in  1  system clock.
- rst_sys  in  1  synchronous active-high reset.
- ptr_fifo_empty  in  NPORTS  per-port descriptor FIFO empty.
- ptr_fifo_rd  out  NPORTS  per-port descriptor pop, one-hot or zero.
- ptr_fifo_dout  in  16*NPORTS  per-port descriptors; port p at bits [16p+15:16p].
- data_fifo_rd  out  NPORTS  per-port byte pop, one-hot or zero.
- data_fifo_dout  in  8*NPORTS  per-port bytes; port p at bits [8p+7:8p].
- o_valid  out  1  output byte valid.
- o_ready  in  1  downstream accepts the byte when o_valid&&o_ready.
- o_data  out  8  frame byte.
- o_sof  out  1  first byte of frame.
- o_eof  out  1  last byte of frame.
- o_err  out  1  descriptor error flag, valid with o_eof.
- o_port  out  PW  source port of the current frame.

Behaviour:
- Descriptor format (fixed):
  - bit 15 = err (CRC or length fault).
  - bits 14:11 reserved, ignored.
  - bits 10:0 = len in bytes, DA through last payload byte; FCS excluded.
- Both FIFOs have 1-cycle read latency: dout is valid the cycle after rd is high.
- Reset values: all *_rd=0, o_valid=0, o_sof=0, o_eof=0, o_err=0, o_data=0, o_port=0, rr pointer=0, state IDLE.
- Reset mid-frame aborts immediately. Bytes left in the data FIFO are not drained; the MAC is reset alongside.
- State machine:
  - IDLE: grant = first port p with !ptr_fifo_empty[p], searching from rr pointer upward with wrap. If any is found, pulse ptr_fifo_rd[grant] for 1 cycle and go to PLAT. Otherwise stay.
  - PLAT: capture len and err from ptr_fifo_dout[grant]; set remaining=len.
    - len==0: go to DONE with no data read and no output.
    - err=1 with MAC_ARB_ERR_DROP_EN: go to DROP.
    - Otherwise: go to XFER.
  - XFER:
    - Assert data_fifo_rd[grant] when remaining>0 and (skid occupancy + reads in flight) < 2; decrement remaining per read.
    - Returned bytes enter a 2-entry skid FIFO; the skid head drives o_data and o_valid.
    - o_sof is high on the first byte only. o_eof and o_err are high on byte len.
    - When eof is accepted (o_valid&&o_ready&&o_eof), go to DONE.
  - DROP: assert data_fifo_rd[grant] every cycle until remaining==0; o_valid stays 0. Then wait 1 cycle for the last read to land and go to DONE.
  - DONE: rr pointer = grant+1, wrapping to 0 past NPORTS-1; go to IDLE.
- Per-frame overhead: 3 cycles (IDLE, PLAT, DONE). First o_valid appears 3 cycles after the ptr_fifo_rd pulse.
- Throughput with o_ready held high: 1 byte/cycle.
- o_data, o_sof, o_eof, o_err and o_port are held stable while o_valid && !o_ready.
- o_port equals grant for the whole frame.
- Never read an empty data FIFO beyond len. Byte count trusts the descriptor.
- At most one bit of ptr_fifo_rd|data_fifo_rd is set per cycle.
- Descriptors arriving on other ports mid-frame wait; there is no preemption.
- remaining is 11 bits; the maximum len of 2047 must not wrap.

Optional Feature:
- Macro: MAC_ARB_ERR_DROP_EN.
- Defined: frames with err=1 are drained through DROP and are invisible downstream. Only the rr pointer advances.
- Undefined: err frames are forwarded like good frames, with o_err=1 on the eof byte. The DROP state is not built.

Test Plan:
- Port 0 descriptor 16'h0040 (64 bytes, ok), o_ready=1 -> 64 consecutive o_valid bytes matching FIFO content; sof on byte 1, eof on byte 64; o_port=0; o_err=0.
- Ports 1, 2, 3 each hold two 60-byte frames, rr=0 at start -> service order 1,2,3,1,2,3; frames never interleave.
- Port 2 descriptor 16'h8064 (err, 100 bytes) followed by a good 60-byte frame:
  - With MAC_ARB_ERR_DROP_EN: exactly 100 data reads, no output, then the 60-byte frame is delivered.
  - Without the macro: 100 bytes are delivered with o_err=1 on eof.
- 1515-byte frame with o_ready toggling 1/0 every cycle -> 1515 bytes delivered in order with no loss or duplication; outputs stable during stalls; data_fifo_rd count = 1515.
- Descriptor len=0 on port 1 -> ptr popped, zero data reads, no o_valid; next frame on port 1 delivered normally.
- rst_sys asserted at byte 30 of a 100-byte frame -> next cycle all outputs at reset values, state IDLE, rr=0.

Source files
------------

// File: rtl/mac_rx_arbiter_if.sv
// Output byte stream of mac_rx_arbiter toward the switch ingress.
//   o_valid/o_ready : ready/valid handshake, byte accepted when both high
//   o_data          : frame byte
//   o_sof/o_eof     : first/last byte of the frame
//   o_err           : descriptor error flag, meaningful with o_eof
//   o_port          : source MAC port of the current frame
// master = arbiter side, slave = switch ingress side.
interface mac_rx_arbiter_if #(
  parameter int unsigned PW = 2
);
  logic          o_valid;
  logic          o_ready;
  logic [7:0]    o_data;
  logic          o_sof;
  logic          o_eof;
  logic          o_err;
  logic [PW-1:0] o_port;

  modport master (
    output o_valid, o_data, o_sof, o_eof, o_err, o_port,
    input  o_ready
  );

  modport slave (
    input  o_valid, o_data, o_sof, o_eof, o_err, o_port,
    output o_ready
  );
endinterface

// File: rtl/mac_rx_arbiter.sv
// Frame-granular round-robin scheduler draining NPORTS MAC receive FIFO
// pairs (descriptor FIFO + byte FIFO) into one byte stream.
//   clk_sys, rst_sys : system clock, synchronous active-high reset
//   ptr_fifo_*       : per-port descriptor FIFOs (1-cycle read latency)
//   data_fifo_*      : per-port byte FIFOs (1-cycle read latency)
//   out_if           : output byte stream (mac_rx_arbiter_if.master)
// Build option: define MAC_ARB_ERR_DROP_EN to silently drain frames whose
// descriptor has err=1 instead of forwarding them.
module mac_rx_arbiter #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned PW     = 2
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys,
  input  logic [NPORTS-1:0]    ptr_fifo_empty,
  output logic [NPORTS-1:0]    ptr_fifo_rd,
  input  logic [16*NPORTS-1:0] ptr_fifo_dout,
  output logic [NPORTS-1:0]    data_fifo_rd,
  input  logic [8*NPORTS-1:0]  data_fifo_dout,
  mac_rx_arbiter_if.master     out_if
);

  localparam int unsigned LW = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAT,
    ST_XFER,
    ST_DONE
`ifdef MAC_ARB_ERR_DROP_EN
    , ST_DROP
`endif
  } state_e;

  typedef struct packed {
    logic sof;
    logic eof;
    logic err;
  } tag_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       err;
  } entry_t;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic            err_q, err_d;
  logic            inflight_q;
  tag_t            tag_q;
  entry_t          skid_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      cnt_q;

  logic [15:0]     ptr_word_c [NPORTS];
  logic [7:0]      byte_word_c [NPORTS];
  logic [3:0]      rsvd_c;
  logic            unused_rsvd_c;
  logic [PW-1:0]   cand_c, pick_c;
  logic            found_c;
  logic [NPORTS-1:0] ptr_rd_c;
  logic            data_rd_c;
  tag_t            tag_c;
  logic [LW-1:0]   cur_len_c;
  logic            cur_err_c;
  entry_t          head_c;
  logic            valid_c, pop_c, wr_c, room_c;
  logic [2:0]      occ_c;

  // Per-port views of the packed FIFO read buses.
  always_comb begin
    rsvd_c = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      ptr_word_c[p]  = ptr_fifo_dout[16*p +: 16];
      byte_word_c[p] = data_fifo_dout[8*p +: 8];
      rsvd_c         = rsvd_c | ptr_fifo_dout[16*p+11 +: 4];
    end
  end
  assign unused_rsvd_c = ^rsvd_c;

  // First non-empty descriptor FIFO at or after the rr pointer, with wrap.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    cand_c  = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      cand_c = PW'((32'(rr_q) + i) % NPORTS);
      if (!found_c && !ptr_fifo_empty[cand_c]) begin
        found_c = 1'b1;
        pick_c  = cand_c;
      end
    end
  end

  assign cur_len_c = ptr_word_c[grant_q][LW-1:0];
  assign cur_err_c = ptr_word_c[grant_q][15];

  // Skid buffer head and handshake.
  assign head_c  = skid_q[rd_ptr_q];
  assign valid_c = (cnt_q != 2'd0);
  assign pop_c   = valid_c && out_if.o_ready;
  assign wr_c    = inflight_q && (state_q == ST_XFER);
  // Slots committed next cycle; a pop this cycle frees one, which keeps
  // 1 byte/cycle flowing with only two entries.
  assign occ_c   = 3'(cnt_q) + 3'(inflight_q) - 3'(pop_c);
  assign room_c  = (occ_c < 3'd2);

  // Next-state and FIFO read strobes.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    rem_d     = rem_q;
    err_d     = err_q;
    ptr_rd_c  = '0;
    data_rd_c = 1'b0;
    tag_c     = '0;
    case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          ptr_rd_c = NPORTS'(1) << pick_c;
          grant_d  = pick_c;
          state_d  = ST_PLAT;
        end
      end
      ST_PLAT: begin
        err_d = cur_err_c;
        rem_d = cur_len_c;
        if (cur_len_c == '0) begin
          state_d = ST_DONE;
        end else begin
          // First byte is fetched here so the first o_valid lands three
          // cycles after the descriptor pop.
          data_rd_c = 1'b1;
          tag_c.sof = 1'b1;
          tag_c.eof = (cur_len_c == LW'(1));
          tag_c.err = (cur_len_c == LW'(1)) && cur_err_c;
          rem_d     = cur_len_c - LW'(1);
`ifdef MAC_ARB_ERR_DROP_EN
          state_d   = cur_err_c ? ST_DROP : ST_XFER;
`else
          state_d   = ST_XFER;
`endif
        end
      end
      ST_XFER: begin
        if ((rem_q != '0) && room_c) begin
          data_rd_c = 1'b1;
          tag_c.eof = (rem_q == LW'(1));
          tag_c.err = (rem_q == LW'(1)) && err_q;
          rem_d     = rem_q - LW'(1);
        end
        if (pop_c && head_c.eof) begin
          state_d = ST_DONE;
        end
      end
`ifdef MAC_ARB_ERR_DROP_EN
      ST_DROP: begin
        if (rem_q != '0) begin
          data_rd_c = 1'b1;
          rem_d     = rem_q - LW'(1);
        end else if (!inflight_q) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        rr_d    = (grant_q == PW'(NPORTS-1)) ? '0 : grant_q + PW'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read strobes are forced low while reset is asserted.
  assign ptr_fifo_rd  = rst_sys ? '0 : ptr_rd_c;
  assign data_fifo_rd = (rst_sys || !data_rd_c) ? '0 : (NPORTS'(1) << grant_q);

  // State, counters and skid buffer.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      inflight_q <= data_rd_c;
      tag_q      <= tag_c;
      if (wr_c) begin
        skid_q[wr_ptr_q] <= '{data: byte_word_c[grant_q], sof: tag_q.sof,
                              eof: tag_q.eof, err: tag_q.err};
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(wr_c) - 2'(pop_c);
    end
  end

  // Flags are qualified by valid so stale skid entries never show.
  assign out_if.o_valid = valid_c;
  assign out_if.o_data  = head_c.data;
  assign out_if.o_sof   = valid_c && head_c.sof;
  assign out_if.o_eof   = valid_c && head_c.eof;
  assign out_if.o_err   = valid_c && head_c.err;
  assign out_if.o_port  = grant_q;

endmodule

// File: tb/tb_mac_rx_arbiter.sv
// Self-checking bench for mac_rx_arbiter: FIFO models, scoreboard of
// expected output beats, one task per scenario.
module tb_mac_rx_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned PW = 2;

  typedef struct packed {
    logic [PW-1:0] port;
    logic          sof;
    logic          eof;
    logic          err;
    logic [7:0]    data;
  } beat_t;

  logic              clk_sys = 1'b0;
  logic              rst_sys = 1'b1;
  logic [NP-1:0]     ptr_fifo_empty = '1;
  logic [NP-1:0]     ptr_fifo_rd;
  logic [16*NP-1:0]  ptr_fifo_dout = '0;
  logic [NP-1:0]     data_fifo_rd;
  logic [8*NP-1:0]   data_fifo_dout = '0;

  mac_rx_arbiter_if #(.PW(PW)) out_if ();

  mac_rx_arbiter #(.NPORTS(NP), .PW(PW)) dut (
    .clk_sys        (clk_sys),
    .rst_sys        (rst_sys),
    .ptr_fifo_empty (ptr_fifo_empty),
    .ptr_fifo_rd    (ptr_fifo_rd),
    .ptr_fifo_dout  (ptr_fifo_dout),
    .data_fifo_rd   (data_fifo_rd),
    .data_fifo_dout (data_fifo_dout),
    .out_if         (out_if)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int passes = 0;

  logic [15:0] pq [NP][$];
  logic [7:0]  dq [NP][$];
  beat_t       expq[$];
  beat_t       obs[$];

  logic [NP-1:0] ptr_rd_s = '0;
  logic [NP-1:0] data_rd_s = '0;
  int ptr_cnt [NP];
  int data_cnt [NP];
  int overread = 0;
  int multi_viol = 0;
  int stall_viol = 0;
  int cyc = 0, ptr_cyc = 0, lat_last = -1, sof_cyc = 0, eof_cyc = 0;
  logic  prev_stall = 1'b0, prev_valid = 1'b0;
  beat_t prev_beat = '0;
  beat_t cur;

  initial begin
    for (int p = 0; p < NP; p++) begin
      ptr_cnt[p]  = 0;
      data_cnt[p] = 0;
    end
  end

  // FIFO models: pop on strobes sampled the previous half cycle.
  always @(posedge clk_sys) begin
    if (rst_sys) begin
      for (int p = 0; p < NP; p++) begin
        pq[p].delete();
        dq[p].delete();
      end
      ptr_fifo_empty <= '1;
      ptr_fifo_dout  <= '0;
      data_fifo_dout <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (ptr_rd_s[p]) begin
          if (pq[p].size() > 0) ptr_fifo_dout[16*p +: 16] <= pq[p].pop_front();
          else overread++;
        end
        if (data_rd_s[p]) begin
          if (dq[p].size() > 0) data_fifo_dout[8*p +: 8] <= dq[p].pop_front();
          else overread++;
        end
        ptr_fifo_empty[p] <= (pq[p].size() == 0);
      end
    end
  end

  // Output monitor and strobe sampling.
  always @(negedge clk_sys) begin
    cyc++;
    ptr_rd_s  = ptr_fifo_rd;
    data_rd_s = data_fifo_rd;
    cur = {out_if.o_port, out_if.o_sof, out_if.o_eof, out_if.o_err, out_if.o_data};
    if (!rst_sys) begin
      if (|ptr_fifo_rd) ptr_cyc = cyc;
      for (int p = 0; p < NP; p++) begin
        if (ptr_fifo_rd[p]) ptr_cnt[p]++;
        if (data_fifo_rd[p]) data_cnt[p]++;
      end
      if ($countones({ptr_fifo_rd, data_fifo_rd}) > 1) multi_viol++;
      if (prev_stall && (!out_if.o_valid || cur !== prev_beat)) stall_viol++;
      if (out_if.o_valid && !prev_valid && out_if.o_sof) lat_last = cyc - ptr_cyc;
      if (out_if.o_valid && out_if.o_ready) begin
        obs.push_back(cur);
        if (out_if.o_sof) sof_cyc = cyc;
        if (out_if.o_eof) eof_cyc = cyc;
      end
    end
    prev_stall = out_if.o_valid && !out_if.o_ready;
    prev_beat  = cur;
    prev_valid = out_if.o_valid;
  end

  // Queue one frame into port p's FIFOs; optionally predict its beats.
  task automatic load_frame(input int p, input int len, input bit err, input bit deliver);
    logic [7:0] b;
    beat_t e;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      dq[p].push_back(b);
      if (deliver) begin
        e.port = PW'(p);
        e.sof  = (i == 0);
        e.eof  = (i == len - 1);
        e.err  = err && (i == len - 1);
        e.data = b;
        expq.push_back(e);
      end
    end
    pq[p].push_back({err, 4'b0, 11'(len)});
  endtask

  task automatic test_reset();
    rst_sys = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if ({out_if.o_valid, out_if.o_sof, out_if.o_eof, out_if.o_err} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000",
               {out_if.o_valid, out_if.o_sof, out_if.o_eof, out_if.o_err});
    else passes++;
    checks++;
    if (out_if.o_data !== 8'h00) $display("FAIL reset_data: got %h want 00", out_if.o_data);
    else passes++;
    checks++;
    if (out_if.o_port !== '0) $display("FAIL reset_port: got %0d want 0", out_if.o_port);
    else passes++;
    checks++;
    if ({ptr_fifo_rd, data_fifo_rd} !== '0)
      $display("FAIL reset_rd: got %b want 0", {ptr_fifo_rd, data_fifo_rd});
    else passes++;
    @(posedge clk_sys); #1 rst_sys = 1'b0;
    repeat (4) @(negedge clk_sys);
    checks++;
    if (out_if.o_valid !== 1'b0 || ptr_fifo_rd !== '0)
      $display("FAIL idle_quiet: valid %b ptr_rd %b want 0", out_if.o_valid, ptr_fifo_rd);
    else passes++;
  endtask

  task automatic test_single_frame();
    int d0;
    beat_t g, w;
    d0 = data_cnt[0];
    @(negedge clk_sys);
    load_frame(0, 64, 1'b0, 1'b1);
    for (int c = 0; c < 400 && obs.size() < 64; c++) @(negedge clk_sys);
    repeat (8) @(negedge clk_sys);
    checks++;
    if (obs.size() != 64) $display("FAIL single_count: got %0d want 64", obs.size());
    else passes++;
    while (obs.size() > 0 && expq.size() > 0) begin
      g = obs.pop_front(); w = expq.pop_front();
      checks++;
      if (g !== w) $display("FAIL single_beat: got %h want %h", g, w);
      else passes++;
    end
    obs.delete(); expq.delete();
    checks++;
    if (lat_last != 3) $display("FAIL single_latency: got %0d want 3", lat_last);
    else passes++;
    checks++;
    if (eof_cyc - sof_cyc != 63) $display("FAIL single_rate: got %0d want 63", eof_cyc - sof_cyc);
    else passes++;
    checks++;
    if (data_cnt[0] - d0 != 64) $display("FAIL single_reads: got %0d want 64", data_cnt[0] - d0);
    else passes++;
  endtask

  task automatic test_round_robin();
    beat_t g, w;
    @(negedge clk_sys);
    for (int f = 0; f < 2; f++)
      for (int p = 1; p < 4; p++) load_frame(p, 60, 1'b0, 1'b1);
    for (int c = 0; c < 2000 && obs.size() < 360; c++) @(negedge clk_sys);
    repeat (8) @(negedge clk_sys);
    checks++;
    if (obs.size() != 360) $display("FAIL rr_count: got %0d want 360", obs.size());
    else passes++;
    while (obs.size() > 0 && expq.size() > 0) begin
      g = obs.pop_front(); w = expq.pop_front();
      checks++;
      if (g !== w) $display("FAIL rr_beat: got %h want %h", g, w);
      else passes++;
    end
    obs.delete(); expq.delete();
    checks++;
    if (multi_viol != 0) $display("FAIL rr_onehot: got %0d multi-hot cycles want 0", multi_viol);
    else passes++;
  endtask

  task automatic test_err_frame();
    int d2, want_n;
    beat_t g, w;
    d2 = data_cnt[2];
    @(negedge clk_sys);
`ifdef MAC_ARB_ERR_DROP_EN
    load_frame(2, 100, 1'b1, 1'b0);
    want_n = 60;
`else
    load_frame(2, 100, 1'b1, 1'b1);
    want_n = 160;
`endif
    load_frame(2, 60, 1'b0, 1'b1);
    for (int c = 0; c < 1000 && obs.size() < want_n; c++) @(negedge clk_sys);
    repeat (8) @(negedge clk_sys);
    checks++;
    if (obs.size() != want_n) $display("FAIL err_count: got %0d want %0d", obs.size(), want_n);
    else passes++;
    while (obs.size() > 0 && expq.size() > 0) begin
      g = obs.pop_front(); w = expq.pop_front();
      checks++;
      if (g !== w) $display("FAIL err_beat: got %h want %h", g, w);
      else passes++;
    end
    obs.delete(); expq.delete();
    checks++;
    if (data_cnt[2] - d2 != 160) $display("FAIL err_reads: got %0d want 160", data_cnt[2] - d2);
    else passes++;
  endtask

  task automatic test_stall();
    int d3, s0;
    beat_t g, w;
    d3 = data_cnt[3];
    s0 = stall_viol;
    @(negedge clk_sys);
    load_frame(3, 1515, 1'b0, 1'b1);
    for (int c = 0; c < 8000 && obs.size() < 1515; c++) begin
      @(posedge clk_sys); #1 out_if.o_ready = ~out_if.o_ready;
    end
    out_if.o_ready = 1'b1;
    repeat (8) @(negedge clk_sys);
    checks++;
    if (obs.size() != 1515) $display("FAIL stall_count: got %0d want 1515", obs.size());
    else passes++;
    while (obs.size() > 0 && expq.size() > 0) begin
      g = obs.pop_front(); w = expq.pop_front();
      checks++;
      if (g !== w) $display("FAIL stall_beat: got %h want %h", g, w);
      else passes++;
    end
    obs.delete(); expq.delete();
    checks++;
    if (stall_viol != s0) $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_viol - s0);
    else passes++;
    checks++;
    if (data_cnt[3] - d3 != 1515) $display("FAIL stall_reads: got %0d want 1515", data_cnt[3] - d3);
    else passes++;
  endtask

  task automatic test_zero_len();
    int p1, d1;
    beat_t g, w;
    p1 = ptr_cnt[1];
    d1 = data_cnt[1];
    @(negedge clk_sys);
    load_frame(1, 0, 1'b0, 1'b1);
    load_frame(1, 20, 1'b0, 1'b1);
    for (int c = 0; c < 300 && obs.size() < 20; c++) @(negedge clk_sys);
    repeat (8) @(negedge clk_sys);
    checks++;
    if (obs.size() != 20) $display("FAIL zero_count: got %0d want 20", obs.size());
    else passes++;
    while (obs.size() > 0 && expq.size() > 0) begin
      g = obs.pop_front(); w = expq.pop_front();
      checks++;
      if (g !== w) $display("FAIL zero_beat: got %h want %h", g, w);
      else passes++;
    end
    obs.delete(); expq.delete();
    checks++;
    if (ptr_cnt[1] - p1 != 2) $display("FAIL zero_ptr_pops: got %0d want 2", ptr_cnt[1] - p1);
    else passes++;
    checks++;
    if (data_cnt[1] - d1 != 20) $display("FAIL zero_reads: got %0d want 20", data_cnt[1] - d1);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    beat_t g, w;
    @(negedge clk_sys);
    load_frame(2, 100, 1'b0, 1'b1);
    for (int c = 0; c < 400 && obs.size() < 30; c++) @(negedge clk_sys);
    @(posedge clk_sys); #1 rst_sys = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ({ptr_fifo_rd, data_fifo_rd} !== '0)
      $display("FAIL rst_mid_rd: got %b want 0", {ptr_fifo_rd, data_fifo_rd});
    else passes++;
    @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if ({out_if.o_valid, out_if.o_sof, out_if.o_eof, out_if.o_err, out_if.o_data, out_if.o_port} !== '0)
      $display("FAIL rst_mid_outputs: got %b want 0",
               {out_if.o_valid, out_if.o_sof, out_if.o_eof, out_if.o_err, out_if.o_data, out_if.o_port});
    else passes++;
    checks++;
    if (obs.size() < 30) $display("FAIL rst_mid_progress: got %0d beats want >=30", obs.size());
    else passes++;
    while (obs.size() > 0 && expq.size() > 0) begin
      g = obs.pop_front(); w = expq.pop_front();
      checks++;
      if (g !== w) $display("FAIL rst_mid_prefix: got %h want %h", g, w);
      else passes++;
    end
    obs.delete(); expq.delete();
    @(posedge clk_sys); #1 rst_sys = 1'b0;
    @(negedge clk_sys);
    // rr restarts at 0, so port 0 wins over port 3.
    load_frame(0, 10, 1'b0, 1'b1);
    load_frame(3, 10, 1'b0, 1'b1);
    for (int c = 0; c < 300 && obs.size() < 20; c++) @(negedge clk_sys);
    repeat (8) @(negedge clk_sys);
    checks++;
    if (obs.size() != 20) $display("FAIL rst_after_count: got %0d want 20", obs.size());
    else passes++;
    while (obs.size() > 0 && expq.size() > 0) begin
      g = obs.pop_front(); w = expq.pop_front();
      checks++;
      if (g !== w) $display("FAIL rst_after_beat: got %h want %h", g, w);
      else passes++;
    end
    obs.delete(); expq.delete();
    checks++;
    if (overread != 0) $display("FAIL overread: got %0d empty pops want 0", overread);
    else passes++;
  endtask

  initial begin
    out_if.o_ready = 1'b1;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_err_frame();
    test_stall();
    test_zero_len();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
